// File: rtl/edge_capture_multi.sv
// Multi-bit sticky edge-capture register with per-bit rise/fall selection, W1C flags,
// overrun tracking, masked interrupt and a saturating captured-edge counter.
module edge_capture_multi #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] overrun,
    output logic [CNT_W-1:0] event_cnt,
    output logic             irq
);

    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] prev_q;
    logic             primed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] dout_next;
    logic [WIDTH-1:0] overrun_next;
    logic [PC_W-1:0]  hit_cnt;
    logic [CNT_W-1:0] cnt_base;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    // Edge detection is held off until one clean sample of din has been taken after reset.
    always_comb begin
        rise         = {WIDTH{primed}} & ~prev_q & din;
        fall         = {WIDTH{primed}} & prev_q & ~din;
        hit          = (rise & rise_en) | (fall & fall_en);
        dout_next    = (dout & ~clr) | hit;
        overrun_next = (overrun & ~clr) | (hit & dout & ~clr);
    end

    // Saturating add of this cycle's captured-edge count.
    always_comb begin
        hit_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            hit_cnt = hit_cnt + PC_W'(hit[i]);
        end
        cnt_base = cnt_clr ? '0 : event_cnt;
        cnt_sum  = SUM_W'(cnt_base) + SUM_W'(hit_cnt);
        if (cnt_sum > SUM_W'(CNT_MAX)) begin
            cnt_next = CNT_MAX;
        end else begin
            cnt_next = CNT_W'(cnt_sum);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            primed    <= 1'b0;
            dout      <= '0;
            overrun   <= '0;
            event_cnt <= '0;
        end else begin
            prev_q    <= din;
            primed    <= 1'b1;
            dout      <= dout_next;
            overrun   <= overrun_next;
            event_cnt <= cnt_next;
        end
    end

    assign irq = |(dout & irq_mask);

endmodule

// File: tb/tb_edge_capture_multi.sv
// Randomized and directed checks of edge_capture_multi (CNT_W=8 and CNT_W=4 instances)
// against a per-bit behavioural model.
module tb_edge_capture_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din, rise_en, fall_en, clr, irq_mask;
    logic        cnt_clr;
    logic [31:0] dout, overrun, dout4, overrun4;
    logic [7:0]  event_cnt;
    logic [3:0]  event_cnt4;
    logic        irq, irq4;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_prev, m_dout, m_ovr;
    bit          m_primed;
    int          m_cnt8, m_cnt4;

    always #5 clk = ~clk;

    edge_capture_multi #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din(din), .rise_en(rise_en), .fall_en(fall_en),
        .clr(clr), .irq_mask(irq_mask), .cnt_clr(cnt_clr),
        .dout(dout), .overrun(overrun), .event_cnt(event_cnt), .irq(irq)
    );

    edge_capture_multi #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .din(din), .rise_en(rise_en), .fall_en(fall_en),
        .clr(clr), .irq_mask(irq_mask), .cnt_clr(cnt_clr),
        .dout(dout4), .overrun(overrun4), .event_cnt(event_cnt4), .irq(irq4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_prev = '0; m_dout = '0; m_ovr = '0; m_primed = 0; m_cnt8 = 0; m_cnt4 = 0;
    endtask

    // One clock of the model, computed bit by bit from the edge rules.
    task automatic model_step();
        logic [31:0] h;
        int          n, t;
        h = '0;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            bit r, f;
            r = m_primed && !m_prev[i] && din[i];
            f = m_primed && m_prev[i] && !din[i];
            if ((r && rise_en[i]) || (f && fall_en[i])) begin
                h[i] = 1'b1;
                n++;
            end
        end
        m_ovr  = (m_ovr & ~clr) | (h & m_dout & ~clr);
        m_dout = (m_dout & ~clr) | h;
        t = (cnt_clr ? 0 : m_cnt8) + n;
        m_cnt8 = (t > 255) ? 255 : t;
        t = (cnt_clr ? 0 : m_cnt4) + n;
        m_cnt4 = (t > 15) ? 15 : t;
        m_prev = din;
        m_primed = 1;
    endtask

    task automatic compare_all();
        chk("dout", 64'(dout), 64'(m_dout));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("event_cnt", 64'(event_cnt), 64'(m_cnt8));
        chk("irq", 64'(irq), 64'(|(m_dout & irq_mask)));
        chk("dout4", 64'(dout4), 64'(m_dout));
        chk("event_cnt4", 64'(event_cnt4), 64'(m_cnt4));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset asserted between clock edges, released away from posedge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_cnt", 64'(event_cnt), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; din = '0; rise_en = '0; fall_en = '1; clr = '0; irq_mask = '0; cnt_clr = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // 1: falling-edge capture on bit 1
        tick();
        din = 32'h2;
        repeat (4) tick();
        din = 32'h0;
        tick();
        chk("t1_dout", 64'(dout), 64'h2);
        repeat (2) tick();
        chk("t1_hold", 64'(dout), 64'h2);
        chk("t1_cnt", 64'(event_cnt), 64'd1);

        // 2: three simultaneous falls
        din = 32'hE;
        repeat (2) tick();
        din = 32'h0;
        tick();
        chk("t2_dout", 64'(dout), 64'hE);
        chk("t2_cnt", 64'(event_cnt), 64'd4);

        // 3: din high through reset release, no capture on priming cycle
        din = '1; rise_en = '1;
        do_reset();
        repeat (3) tick();
        chk("t3_dout", 64'(dout), 64'h0);
        chk("t3_cnt", 64'(event_cnt), 64'd0);

        // 4: overrun, then clear racing a new fall
        din = '0; rise_en = '0; fall_en = '1;
        do_reset();
        tick();
        din = 32'h1; tick(); din = 32'h0; tick();
        chk("t4_dout", 64'(dout), 64'h1);
        chk("t4_ovr0", 64'(overrun), 64'h0);
        din = 32'h1; tick(); din = 32'h0; tick();
        chk("t4_ovr1", 64'(overrun), 64'h1);
        din = 32'h1; tick(); din = 32'h0; clr = 32'h1; tick();
        clr = '0;
        chk("t4_dout_set", 64'(dout), 64'h1);
        chk("t4_ovr_clr", 64'(overrun), 64'h0);

        // 5: saturation of 4-bit counter, cnt_clr with two hits
        rise_en = 32'h1; fall_en = 32'h1;
        do_reset();
        tick();
        for (int k = 0; k < 20; k++) begin
            din = din ^ 32'h1;
            tick();
        end
        chk("t5_cnt4_sat", 64'(event_cnt4), 64'd15);
        chk("t5_cnt8", 64'(event_cnt), 64'd20);
        rise_en = 32'h3; fall_en = 32'h3; din = 32'h3; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t5_cnt4_clr", 64'(event_cnt4), 64'd2);
        chk("t5_cnt8_clr", 64'(event_cnt), 64'd2);

        // 6: masked irq, then async reset mid-cycle
        din = '0; rise_en = '1; fall_en = '0; irq_mask = 32'h4;
        do_reset();
        tick();
        din = 32'h6;
        tick();
        chk("t6_dout", 64'(dout), 64'h6);
        chk("t6_irq", 64'(irq), 64'd1);
        do_reset();
        tick();

        // Random soak
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                rise_en  = $urandom;
                fall_en  = $urandom;
                irq_mask = $urandom;
            end
            din     = din ^ ($urandom & $urandom);
            clr     = $urandom & $urandom & $urandom;
            cnt_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
